host_write_packer: RTL

Upstream feeder for the VRAM write FIFO. Takes byte-wide writes from the asynchronous host bus, synchronises the write strobe, pairs low/high bytes into 16-bit words and pushes each completed word into the FIFO that the managed VRAM copy stage drains. Throttles the host with a ready line while the FIFO is full and flags any write that arrives despite the throttle.

---
 rtl/vram_pkg.sv | 10 +
 rtl/strobe_sync.sv | 26 ++
 rtl/host_write_packer.sv | 106 ++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM write path: packer FSM states and data widths.
package vram_pkg;
    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int WORD_W              = 16;
endpackage

// File: rtl/strobe_sync.sv
// Brings the asynchronous active-low host strobe into the clock domain and
// emits a one-cycle event on its synchronised falling edge.
module strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic strobe_n,
    output logic event_pulse
);
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    // Idle level is high, so every flop resets to 1 to avoid a spurious edge after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_reg <= '1;
            prev_reg <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], strobe_n};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign event_pulse = prev_reg & ~sync_reg[SYNC_STAGES-1];
endmodule

// File: rtl/host_write_packer.sv
// Pairs host low/high byte writes into 16-bit words and pushes them into the
// VRAM write FIFO, stalling the host while the FIFO is full.
module host_write_packer
    import vram_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              host_wr_n,
    input  logic              host_a0,
    input  logic [7:0]        host_data,
    input  logic              fifo_full,
    input  logic              clear_overrun,
    output logic              fifo_wr,
    output logic [WORD_W-1:0] fifo_data,
    output logic              host_ready,
    output logic              overrun,
    output logic [15:0]       words_pushed
);
    logic              event_pulse;
    state_t            state_reg, state_next;
    logic [7:0]        lo_byte_reg, lo_byte_next;
    logic              fifo_wr_reg, fifo_wr_next;
    logic [WORD_W-1:0] fifo_data_reg, fifo_data_next;
    logic              host_ready_reg, host_ready_next;
    logic              overrun_reg, overrun_next;
    logic [15:0]       count_reg, count_next;

    strobe_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_strobe_sync (
        .clock      (clock),
        .reset      (reset),
        .strobe_n   (host_wr_n),
        .event_pulse(event_pulse)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            lo_byte_reg    <= 8'h00;
            fifo_wr_reg    <= 1'b0;
            fifo_data_reg  <= '0;
            host_ready_reg <= 1'b1;
            overrun_reg    <= 1'b0;
            count_reg      <= 16'h0000;
        end else begin
            state_reg      <= state_next;
            lo_byte_reg    <= lo_byte_next;
            fifo_wr_reg    <= fifo_wr_next;
            fifo_data_reg  <= fifo_data_next;
            host_ready_reg <= host_ready_next;
            overrun_reg    <= overrun_next;
            count_reg      <= count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        lo_byte_next    = lo_byte_reg;
        fifo_wr_next    = 1'b0;
        fifo_data_next  = fifo_data_reg;
        host_ready_next = host_ready_reg;
        overrun_next    = overrun_reg & ~clear_overrun;
        count_next      = count_reg;

        case (state_reg)
            IDLE: begin
                if (event_pulse) begin
                    if (!host_a0) begin
                        lo_byte_next = host_data;
                    end else begin
                        fifo_data_next = {host_data, lo_byte_reg};
                        if (fifo_full) begin
                            state_next      = STALL;
                            host_ready_next = 1'b0;
                        end else begin
                            fifo_wr_next = 1'b1;
                            count_next   = count_reg + 16'd1;
                        end
                    end
                end
            end
            STALL: begin
                // The held word stays in fifo_data; any host write here is lost.
                if (!fifo_full) begin
                    fifo_wr_next    = 1'b1;
                    count_next      = count_reg + 16'd1;
                    host_ready_next = 1'b1;
                    state_next      = IDLE;
                end
                if (event_pulse) begin
                    overrun_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign fifo_wr      = fifo_wr_reg;
    assign fifo_data    = fifo_data_reg;
    assign host_ready   = host_ready_reg;
    assign overrun      = overrun_reg;
    assign words_pushed = count_reg;
endmodule
